// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
// Holds the fetch FSM state encoding, entry layout, instruction width,
// PC increment and the default queue depth.
package ifq_pkg;

    localparam int          INST_W        = 32;
    localparam logic [31:0] PC_INC        = 32'd4;
    localparam int          DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } ifq_state_e;

    // One queue entry: the PC the word was fetched from plus the word itself.
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_if.sv
// Bus bundle between the prefetch queue, instruction memory and IF/ID.
// master: the prefetch queue (drives imem_req/addr and the inst_* outputs).
// slave : the environment (memory responses, redirects, IF/ID accept).
interface ifq_if;
    import ifq_pkg::*;

    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_out;
    logic [31:0]       pc_plus4_out;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, pc_plus4_out,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, pc_plus4_out,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/ifq_fifo.sv
// Purpose: entry storage for the prefetch queue (push/pop/clear, occupancy count).
// Latency: a pushed entry is visible at head_dat/count the cycle after the push.
// Backpressure: none internally; caller must not push when full. Pop on empty is ignored.
// Ports: clk, rst (sync, active-high), clear (flush, wins over push/pop),
//        push/push_dat, pop, head_dat (combinational head), count (0..DEPTH).
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  ifq_entry_t             push_dat,
    input  logic                   pop,
    output ifq_entry_t             head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ifq_entry_t    mem_q [DEPTH];
    ifq_entry_t    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Purpose: instruction prefetch queue; one-outstanding fetch FSM feeding a DEPTH-entry FIFO to IF/ID.
// Latency: a word returned in cycle N is presented at inst_valid/inst_out in cycle N+1.
// Backpressure: inst_ready low lets the queue fill; at DEPTH entries no new request is issued.
// Ports: clk, rst (sync, active-high); bus (ifq_if.master): imem_req/addr/gnt/rvalid/rdata,
//        redirect_valid/pc, inst_valid/ready, inst_out, pc_plus4_out.
// Optional IFQ_PERF_CNT_EN: adds fetch_count (pushes) and flush_count (redirects), wrapping at 2^32.
module if_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifq_if.master       bus
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_e    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] fifo_count;
    ifq_entry_t    push_dat, head_dat;
    logic          full, req, push, pop, clear, redirect;
    logic [31:0]   redir_pc;

    assign redirect = bus.redirect_valid;
    assign redir_pc = bus.redirect_pc & ~32'h3;
    assign full     = (fifo_count == CW'(DEPTH));
    assign push_dat = '{pc: fetch_pc_q, inst: bus.imem_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req        = 1'b0;
        push       = 1'b0;
        clear      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // Requests only issue with a free slot, so every response has room.
                req = !full;
                if (req && bus.imem_gnt) begin
                    // A redirect racing the grant still owes us one response to swallow.
                    state_d = redirect ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = ST_FETCH;
                    if (!redirect) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_INC;
                    end
                end else if (redirect) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Redirect overrides any push/pop and the sequential PC update.
        if (redirect) begin
            clear      = 1'b1;
            fetch_pc_d = redir_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    // Outputs are forced quiet in the reset cycle itself, before the flops clear.
    assign bus.imem_req     = req && !rst;
    assign bus.imem_addr    = fetch_pc_q;
    assign bus.inst_valid   = (fifo_count != '0) && !rst;
    assign bus.inst_out     = head_dat.inst;
    assign bus.pc_plus4_out = head_dat.pc + PC_INC;
    assign pop              = bus.inst_valid && bus.inst_ready && !redirect;

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + (push     ? 32'd1 : 32'd0);
        flush_count_d = flush_count_q + (redirect ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: memory responder with a grant budget,
// expected-delivery queue filled by the stimulus and drained by an output monitor.
module tb_if_prefetch_queue;
    import ifq_pkg::*;

    logic clk;
    logic rst;
    ifq_if bus();
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IFQ_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks    = 0;
    int          errors    = 0;
    int          budget    = 0;
    int          rsp_delay = 1;
    int          pend_cnt  = 0;
    int          grant_cnt = 0;
    int          rsp_cnt   = 0;
    logic [31:0] pend_addr = '0;
    logic        ovr_vld   = 1'b0;
    logic [31:0] ovr_dat   = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back('{pc4: a + 32'd4, inst: data_of(a)});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_empty(input string tag, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        budget             = 0;
        rsp_delay          = 1;
        exp_q.delete();
        tick(3);
        grant_cnt = 0;
        rsp_cnt   = 0;
    endtask

    // Memory model: grants while budget lasts, answers rsp_delay cycles after a grant.
    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #2;
            bus.imem_rvalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = ovr_vld ? ovr_dat : data_of(pend_addr);
                    ovr_vld         = 1'b0;
                    rsp_cnt++;
                end
            end
            bus.imem_gnt = (budget > 0);
            if (bus.imem_req && bus.imem_gnt) begin
                budget--;
                grant_cnt++;
                pend_cnt  = rsp_delay;
                pend_addr = bus.imem_addr;
            end
        end
    end

    // Output monitor: every accepted head entry must match the next expectation.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_inst observed=%h expected=none", bus.inst_out);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("inst_out", bus.inst_out, mon_e.inst);
                    check("pc_plus4_out", bus.pc_plus4_out, mon_e.pc4);
                end
            end
        end
    end

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        tick(2);
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);

        // Streaming from reset: 0,4,8 delivered with one-cycle latency.
        budget         = 3;
        bus.inst_ready = 1'b1;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        rst = 1'b0;
        tick(1);
        check("t1_first_req", bus.imem_req, 1);
        check("t1_first_addr", bus.imem_addr, 32'h0);
        tick(1);
        check("t1_wait_noreq", bus.imem_req, 0);
        check("t1_wait_empty", bus.inst_valid, 0);
        tick(1);
        check("t1_latency_valid", bus.inst_valid, 1);
        check("t1_next_addr", bus.imem_addr, 32'h4);
        wait_empty("t1_drain", 40);
        tick(2);
        check("t1_end_addr", bus.imem_addr, 32'hC);
        check("t1_end_empty", bus.inst_valid, 0);

        // Full queue stalls requests; accepting resumes at 16.
        do_reset();
        budget = 5;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (grant_cnt == 4 && rsp_cnt == 4 && !bus.imem_req) break;
            tick(1);
        end
        tick(3);
        check("t2_pushes", grant_cnt, 4);
        check("t2_full_noreq", bus.imem_req, 0);
        check("t2_full_addr", bus.imem_addr, 32'h10);
        check("t2_full_valid", bus.inst_valid, 1);
        bus.inst_ready = 1'b1;
        tick(1);
        check("t2_resume_req", bus.imem_req, 1);
        check("t2_resume_addr", bus.imem_addr, 32'h10);
        wait_empty("t2_drain", 40);

        // Redirect with 3 entries queued; low pc bits are dropped.
        do_reset();
        budget = 3;
        rst    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_cnt == 3) break;
            tick(1);
        end
        tick(1);
        check("t3_rsp", rsp_cnt, 3);
        check("t3_pre_valid", bus.inst_valid, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h43;
        push_exp(32'h40);
        tick(1);
        bus.redirect_valid = 1'b0;
        check("t3_flush_valid", bus.inst_valid, 0);
        check("t3_redir_req", bus.imem_req, 1);
        check("t3_redir_addr", bus.imem_addr, 32'h40);
        budget         = 1;
        bus.inst_ready = 1'b1;
        wait_empty("t3_drain", 40);

        // Redirect while waiting: late 0xDEAD response must be swallowed.
        do_reset();
        budget         = 1;
        rsp_delay      = 2;
        ovr_vld        = 1'b1;
        ovr_dat        = 32'h0000_DEAD;
        bus.inst_ready = 1'b1;
        rst            = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (grant_cnt == 1) break;
            tick(1);
        end
        check("t4_grant", grant_cnt, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        rsp_delay          = 1;
        budget             = 1;
        push_exp(32'h80);
        tick(1);
        bus.redirect_valid = 1'b0;
        check("t4_drain_noreq", bus.imem_req, 0);
        tick(1);
        check("t4_refetch_req", bus.imem_req, 1);
        check("t4_refetch_addr", bus.imem_addr, 32'h80);
        check("t4_dead_dropped", bus.inst_valid, 0);
        wait_empty("t4_drain", 40);

        // Reset while waiting with 2 entries queued.
        do_reset();
        budget = 3;
        rst    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (grant_cnt == 3) break;
            tick(1);
        end
        check("t5_grant", grant_cnt, 3);
        check("t5_pre_valid", bus.inst_valid, 1);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        check("t5_rst_valid", bus.inst_valid, 0);
        check("t5_rst_req", bus.imem_req, 0);
        tick(2);
        budget         = 1;
        bus.inst_ready = 1'b1;
        push_exp(32'h0);
        rst = 1'b0;
        tick(1);
        check("t5_restart_req", bus.imem_req, 1);
        check("t5_restart_addr", bus.imem_addr, 32'h0);
        wait_empty("t5_drain", 40);

        // Five fetches then two redirects.
        do_reset();
`ifdef IFQ_PERF_CNT_EN
        check("t6_fetch_cnt_rst", fetch_count, 0);
        check("t6_flush_cnt_rst", flush_count, 0);
`endif
        budget         = 5;
        bus.inst_ready = 1'b1;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
        rst = 1'b0;
        wait_empty("t6_drain", 60);
        tick(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(2);
        check("t6_final_addr", bus.imem_addr, 32'h200);
`ifdef IFQ_PERF_CNT_EN
        check("t6_fetch_count", fetch_count, 5);
        check("t6_flush_count", flush_count, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address, word aligned.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  input  1  fetched word is valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-012 inst_valid  output  1  head entry is available to IF/ID.
REQ-013 inst_ready  input  1  IF/ID accepts the head entry (the IF/ID write enable).
REQ-014 inst_out  output  32  head instruction.
REQ-015 pc_plus4_out  output  32  head entry PC + 4.

Function
REQ-016 States: IDLE, FETCH, WAIT, DRAIN; at most one request outstanding.
REQ-017 IDLE: only during reset; moves to FETCH on the first cycle with rst low.
REQ-018 FETCH: imem_req=1 and imem_addr=fetch_pc while count<DEPTH; imem_req && imem_gnt moves to WAIT.
REQ-019 WAIT: imem_rvalid pushes {fetch_pc, imem_rdata}, adds 4 to fetch_pc modulo 2^32, and returns to FETCH.
REQ-020 imem_req=0 in WAIT, DRAIN and IDLE; imem_addr holds fetch_pc at all times.
REQ-021 inst_valid=(count!=0); inst_out and pc_plus4_out are combinational from the head entry.
REQ-022 Pop on inst_valid && inst_ready && !redirect_valid; a push and pop in the same cycle leave count unchanged.
REQ-023 Full: count==DEPTH blocks new requests; a request issues only when count<DEPTH, so a granted response always has room.
REQ-024 Empty: inst_valid=0; inst_ready is ignored.
REQ-025 Redirect has priority over push and pop: queue cleared, fetch_pc=redirect_pc, pointers reset.
REQ-026 Redirect in WAIT without same-cycle imem_rvalid moves to DRAIN; the next imem_rvalid is discarded and the state moves to FETCH.
REQ-027 Redirect in WAIT with same-cycle imem_rvalid discards that word and moves to FETCH.
REQ-028 Redirect in FETCH with same-cycle grant discards the grant's response via WAIT->DRAIN handling, i.e., it moves to DRAIN.
REQ-029 Redirect in DRAIN updates fetch_pc and stays in DRAIN until imem_rvalid.
REQ-030 Latency: with an empty queue, a word arriving at cycle N is visible at inst_valid in cycle N+1.
REQ-031 The first request after a redirect issues in the cycle after the redirect (FETCH case).

Reset
REQ-032 While rst is high: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0, inst_valid=0.
REQ-033 Reset mid-operation abandons any outstanding request; responses arriving during or after reset without a matching request are ignored.

Configuration
REQ-034 Macro IFQ_PERF_CNT_EN defined: adds outputs fetch_count[31:0] (pushes) and flush_count[31:0] (redirects).
REQ-035 Both counters are zero on reset and wrap at 2^32.
REQ-036 Macro undefined: neither counter port nor its logic exists; all other behaviour is identical.

Structure
REQ-037 Shared package ifq_pkg holds:
- state encoding (IDLE/FETCH/WAIT/DRAIN)
- instruction width 32
- PC increment 4
- default DEPTH
REQ-038 One sub-module ifq_fifo provides the entry storage and pointers (push/pop/clear, count); the FSM stays in the top.

Verification
REQ-039 Reset release, imem_gnt=1, rvalid one cycle after grant, inst_ready=1 -> inst_out sequence from addresses 0,4,8; pc_plus4_out=4,8,12.
REQ-040 inst_ready=0, DEPTH=4 -> exactly 4 pushes, then imem_req=0; raising inst_ready resumes fetching at addr 16.
REQ-041 Queue holding 3 entries, redirect_valid with redirect_pc=32'h40 -> next cycle inst_valid=0; next request addr 0x40.
REQ-042 Redirect to 0x80 while in WAIT; rvalid 2 cycles later with 0xDEAD -> 0xDEAD never appears at inst_out; first delivered pc_plus4_out=0x84.
REQ-043 rst asserted while WAIT and 2 entries queued -> next cycle inst_valid=0, imem_req=0; after release, fetch from RESET_PC.
REQ-044 With IFQ_PERF_CNT_EN: 5 fetches and 2 redirects -> fetch_count=5, flush_count=2.
